aes_axi_lite_regs: RTL and testbench

AXI4-Lite slave register bank that fronts the 41-clock LUT-based AES-128 encryption core. Software writes key and plaintext words, issues START, then polls STATUS or waits for `irq` and reads back ciphertext. It sits between the AXI interconnect, driven by the master VIP in simulation, and the AES core. It owns all bus handshakes, the register map, the core start/done handshake and a per-operation cycle counter.

---
 rtl/aes_axi_lite_regs.sv | 192 +++++++++++++++++++
 tb/tb_aes_axi_lite_regs.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_axi_lite_regs.sv
// AXI4-Lite register bank in front of the AES-128 core: key/plaintext/ciphertext
// registers, start/done handshake, status with W1C bits, and a per-operation cycle counter.
module aes_axi_lite_regs #(
   parameter int C_S_AXI_DATA_WIDTH = 32,
   parameter int C_S_AXI_ADDR_WIDTH = 6
) (
   input  logic                            S_AXI_ACLK,
   input  logic                            S_AXI_ARESETN,
   input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
   input  logic [2:0]                      S_AXI_AWPROT,
   input  logic                            S_AXI_AWVALID,
   output logic                            S_AXI_AWREADY,
   input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
   input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
   input  logic                            S_AXI_WVALID,
   output logic                            S_AXI_WREADY,
   output logic [1:0]                      S_AXI_BRESP,
   output logic                            S_AXI_BVALID,
   input  logic                            S_AXI_BREADY,
   input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
   input  logic [2:0]                      S_AXI_ARPROT,
   input  logic                            S_AXI_ARVALID,
   output logic                            S_AXI_ARREADY,
   output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
   output logic [1:0]                      S_AXI_RRESP,
   output logic                            S_AXI_RVALID,
   input  logic                            S_AXI_RREADY,
   output logic [127:0]                    aes_key,
   output logic [127:0]                    aes_pt,
   output logic                            aes_start,
   input  logic [127:0]                    aes_ct,
   input  logic                            aes_done,
   output logic                            irq
);

   localparam int DW = C_S_AXI_DATA_WIDTH;
   localparam int NB = C_S_AXI_DATA_WIDTH / 8;

   typedef enum logic {W_IDLE, W_RESP} w_state_t;
   typedef enum logic {R_IDLE, R_DATA} r_state_t;

   w_state_t      w_state;
   r_state_t      r_state;
   logic [DW-1:0] key_q [4];
   logic [DW-1:0] pt_q  [4];
   logic [DW-1:0] ct_q  [4];
   logic          ie_q;
   logic          busy_q;
   logic          done_q;
   logic          overrun_q;
   logic [15:0]   cycles_q;
   logic [3:0]    w_idx;
   logic [3:0]    r_idx;
   logic [DW-1:0] rd_mux;
   logic          unused_ok;

   assign w_idx       = S_AXI_AWADDR[5:2];
   assign r_idx       = S_AXI_ARADDR[5:2];
   assign aes_key     = {key_q[0], key_q[1], key_q[2], key_q[3]};
   assign aes_pt      = {pt_q[0], pt_q[1], pt_q[2], pt_q[3]};
   assign irq         = done_q & ie_q;
   assign S_AXI_RRESP = 2'b00;
   assign unused_ok   = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

   // Write channel FSM and the whole register bank share one process so the
   // done path can be placed after the bus write and win over a same-cycle W1C.
   always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
      if (!S_AXI_ARESETN) begin
         w_state       <= W_IDLE;
         S_AXI_AWREADY <= 1'b0;
         S_AXI_WREADY  <= 1'b0;
         S_AXI_BVALID  <= 1'b0;
         S_AXI_BRESP   <= 2'b00;
         aes_start     <= 1'b0;
         ie_q          <= 1'b0;
         busy_q        <= 1'b0;
         done_q        <= 1'b0;
         overrun_q     <= 1'b0;
         cycles_q      <= '0;
         for (int unsigned i = 0; i < 4; i++) begin
            key_q[i] <= '0;
            pt_q[i]  <= '0;
            ct_q[i]  <= '0;
         end
      end else begin
         aes_start <= 1'b0;
         case (w_state)
            W_IDLE: begin
               if (S_AXI_AWREADY) begin
                  S_AXI_AWREADY <= 1'b0;
                  S_AXI_WREADY  <= 1'b0;
                  S_AXI_BVALID  <= 1'b1;
                  S_AXI_BRESP   <= 2'b00;
                  w_state       <= W_RESP;
                  if (!w_idx[3]) begin
                     if (busy_q) begin
                        S_AXI_BRESP <= 2'b10;
                     end else begin
                        for (int unsigned b = 0; b < NB; b++) begin
                           if (S_AXI_WSTRB[b]) begin
                              if (!w_idx[2]) key_q[w_idx[1:0]][8*b +: 8] <= S_AXI_WDATA[8*b +: 8];
                              else           pt_q[w_idx[1:0]][8*b +: 8]  <= S_AXI_WDATA[8*b +: 8];
                           end
                        end
                     end
                  end else if (w_idx == 4'd8 && S_AXI_WSTRB[0]) begin
                     ie_q <= S_AXI_WDATA[1];
                     if (S_AXI_WDATA[0]) begin
                        if (busy_q) begin
                           overrun_q <= 1'b1;
                        end else begin
                           aes_start <= 1'b1;
                           busy_q    <= 1'b1;
                           done_q    <= 1'b0;
                           cycles_q  <= 16'd1;
                        end
                     end
                  end else if (w_idx == 4'd9 && S_AXI_WSTRB[0]) begin
                     if (S_AXI_WDATA[1]) done_q    <= 1'b0;
                     if (S_AXI_WDATA[2]) overrun_q <= 1'b0;
                  end
               end else if (S_AXI_AWVALID && S_AXI_WVALID) begin
                  S_AXI_AWREADY <= 1'b1;
                  S_AXI_WREADY  <= 1'b1;
               end
            end
            W_RESP: begin
               if (S_AXI_BREADY) begin
                  S_AXI_BVALID <= 1'b0;
                  w_state      <= W_IDLE;
               end
            end
            default: w_state <= W_IDLE;
         endcase

         if (busy_q) begin
            if (aes_done) begin
               for (int unsigned i = 0; i < 4; i++) begin
                  ct_q[i] <= aes_ct[4*DW-1-DW*i -: DW];
               end
               busy_q <= 1'b0;
               done_q <= 1'b1;
            end else if (cycles_q != 16'hFFFF) begin
               cycles_q <= cycles_q + 16'd1;
            end
         end
      end
   end

   always_comb begin
      rd_mux = '0;
      case (r_idx)
         4'd0, 4'd1, 4'd2, 4'd3:     rd_mux = key_q[r_idx[1:0]];
         4'd4, 4'd5, 4'd6, 4'd7:     rd_mux = pt_q[r_idx[1:0]];
         4'd8:                       rd_mux[1] = ie_q;
         4'd9:                       rd_mux[2:0] = {overrun_q, done_q, busy_q};
         4'd10, 4'd11, 4'd12, 4'd13: rd_mux = ct_q[r_idx[1:0] - 2'd2];
         4'd14:                      rd_mux[15:0] = cycles_q;
         default:                    rd_mux = '0;
      endcase
   end

   always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
      if (!S_AXI_ARESETN) begin
         r_state       <= R_IDLE;
         S_AXI_ARREADY <= 1'b0;
         S_AXI_RVALID  <= 1'b0;
         S_AXI_RDATA   <= '0;
      end else begin
         case (r_state)
            R_IDLE: begin
               if (S_AXI_ARREADY) begin
                  S_AXI_ARREADY <= 1'b0;
                  S_AXI_RVALID  <= 1'b1;
                  S_AXI_RDATA   <= rd_mux;
                  r_state       <= R_DATA;
               end else if (S_AXI_ARVALID) begin
                  S_AXI_ARREADY <= 1'b1;
               end
            end
            R_DATA: begin
               if (S_AXI_RREADY) begin
                  S_AXI_RVALID <= 1'b0;
                  r_state      <= R_IDLE;
               end
            end
            default: r_state <= R_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_aes_axi_lite_regs.sv
// Bench for aes_axi_lite_regs: directed + randomized AXI-Lite traffic against a
// register-level model, with a 41-clock core stand-in and per-cycle output checks.
module tb_aes_axi_lite_regs;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic [5:0]   awaddr = '0;
   logic [2:0]   awprot = '0;
   logic         awvalid = 1'b0;
   logic         awready;
   logic [31:0]  wdata = '0;
   logic [3:0]   wstrb = '0;
   logic         wvalid = 1'b0;
   logic         wready;
   logic [1:0]   bresp;
   logic         bvalid;
   logic         bready = 1'b0;
   logic [5:0]   araddr = '0;
   logic [2:0]   arprot = '0;
   logic         arvalid = 1'b0;
   logic         arready;
   logic [31:0]  rdata;
   logic [1:0]   rresp;
   logic         rvalid;
   logic         rready = 1'b0;
   logic [127:0] aes_key;
   logic [127:0] aes_pt;
   logic         aes_start;
   logic [127:0] aes_ct = '0;
   logic         aes_done = 1'b0;
   logic         irq;

   always #5 clk = ~clk;

   aes_axi_lite_regs #(.C_S_AXI_DATA_WIDTH(32), .C_S_AXI_ADDR_WIDTH(6)) dut (
      .S_AXI_ACLK(clk), .S_AXI_ARESETN(rst_n),
      .S_AXI_AWADDR(awaddr), .S_AXI_AWPROT(awprot), .S_AXI_AWVALID(awvalid), .S_AXI_AWREADY(awready),
      .S_AXI_WDATA(wdata), .S_AXI_WSTRB(wstrb), .S_AXI_WVALID(wvalid), .S_AXI_WREADY(wready),
      .S_AXI_BRESP(bresp), .S_AXI_BVALID(bvalid), .S_AXI_BREADY(bready),
      .S_AXI_ARADDR(araddr), .S_AXI_ARPROT(arprot), .S_AXI_ARVALID(arvalid), .S_AXI_ARREADY(arready),
      .S_AXI_RDATA(rdata), .S_AXI_RRESP(rresp), .S_AXI_RVALID(rvalid), .S_AXI_RREADY(rready),
      .aes_key(aes_key), .aes_pt(aes_pt), .aes_start(aes_start),
      .aes_ct(aes_ct), .aes_done(aes_done), .irq(irq)
   );

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // Register-level model: state as the software map defines it.
   logic [31:0]  m_key [4];
   logic [31:0]  m_pt  [4];
   logic [31:0]  m_ct  [4];
   logic         m_ie, m_busy, m_done, m_ovr;
   int           m_start_cyc, m_start_edge, m_frozen;
   logic [127:0] core_ct = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at cycle %0d", name, act, exp, cyc);
      end
   endtask

   function automatic void model_reset();
      for (int i = 0; i < 4; i++) begin
         m_key[i] = '0; m_pt[i] = '0; m_ct[i] = '0;
      end
      m_ie = 1'b0; m_busy = 1'b0; m_done = 1'b0; m_ovr = 1'b0;
      m_start_cyc = 0; m_start_edge = -1; m_frozen = 0;
   endfunction

   function automatic logic [1:0] model_write(input int idx, input logic [31:0] d, input logic [3:0] s);
      if (idx < 8) begin
         if (m_busy) return 2'b10;
         for (int b = 0; b < 4; b++) begin
            if (s[b]) begin
               if (idx < 4) m_key[idx][8*b +: 8] = d[8*b +: 8];
               else         m_pt[idx-4][8*b +: 8] = d[8*b +: 8];
            end
         end
      end else if (idx == 8 && s[0]) begin
         m_ie = d[1];
         if (d[0]) begin
            if (m_busy) m_ovr = 1'b1;
            else begin
               m_busy = 1'b1; m_done = 1'b0; m_start_cyc = cyc; m_start_edge = cyc;
            end
         end
      end else if (idx == 9 && s[0]) begin
         if (d[1]) m_done = 1'b0;
         if (d[2]) m_ovr = 1'b0;
      end
      return 2'b00;
   endfunction

   function automatic logic [31:0] model_read(input int idx);
      logic [31:0] v = '0;
      int c;
      if (idx < 4)       v = m_key[idx];
      else if (idx < 8)  v = m_pt[idx-4];
      else if (idx == 8) v[1] = m_ie;
      else if (idx == 9) v[2:0] = {m_ovr, m_done, m_busy};
      else if (idx < 14) v = m_ct[idx-10];
      else if (idx == 14) begin
         c = m_busy ? (cyc - m_start_cyc) : m_frozen;
         if (c > 65535) c = 65535;
         v = 32'(c);
      end
      return v;
   endfunction

   // Per-cycle compare of the core-facing outputs and the interrupt.
   always @(negedge clk) begin
      chk("aes_key", aes_key, {m_key[0], m_key[1], m_key[2], m_key[3]});
      chk("aes_pt", aes_pt, {m_pt[0], m_pt[1], m_pt[2], m_pt[3]});
      chk("irq", 128'(irq), 128'(m_done & m_ie));
      chk("aes_start", 128'(aes_start), 128'(cyc == m_start_edge));
   end

   // Core stand-in: done pulse in the 40th cycle after the start cycle.
   initial begin
      logic [127:0] ct_now;
      forever begin
         @(posedge clk); #1;
         if (aes_start === 1'b1) begin
            ct_now = core_ct;
            repeat (40) @(posedge clk);
            #1; aes_done = 1'b1; aes_ct = ct_now;
            @(posedge clk); #2;
            if (m_busy) begin
               for (int i = 0; i < 4; i++) m_ct[i] = ct_now[127-32*i -: 32];
               m_busy = 1'b0; m_done = 1'b1;
               m_frozen = cyc - m_start_cyc;
               if (m_frozen > 65535) m_frozen = 65535;
            end
            aes_done = 1'b0;
         end
      end
   end

   task automatic step();
      @(posedge clk); #1;
   endtask

   task automatic axi_write(input int idx, input logic [31:0] d, input logic [3:0] s,
                            input int lead, input int bp, output logic [1:0] resp);
      logic [1:0] exp;
      awaddr = 6'(idx * 4 + int'($urandom_range(0, 3)));
      wdata = d; wstrb = s;
      if (lead >= 0) begin
         awvalid = 1'b1;
         for (int i = 0; i < lead; i++) begin step(); chk("awready_early", 128'(awready), 128'(0)); end
         wvalid = 1'b1;
      end else begin
         wvalid = 1'b1;
         for (int i = 0; i < -lead; i++) begin step(); chk("wready_early", 128'(wready), 128'(0)); end
         awvalid = 1'b1;
      end
      step();
      chk("aw_w_ready", 128'({awready, wready}), 128'(2'b11));
      step();
      awvalid = 1'b0; wvalid = 1'b0;
      exp = model_write(idx, d, s);
      chk("bvalid", 128'(bvalid), 128'(1));
      chk("bresp", 128'(bresp), 128'(exp));
      chk("awready_drop", 128'(awready), 128'(0));
      resp = bresp;
      for (int i = 0; i < bp; i++) begin
         step(); chk("b_hold", 128'({bvalid, bresp}), 128'({1'b1, exp}));
      end
      bready = 1'b1; step(); bready = 1'b0;
      chk("bvalid_clear", 128'(bvalid), 128'(0));
   endtask

   task automatic axi_read(input int idx, input int rp, output logic [31:0] val);
      logic [31:0] exp;
      araddr = 6'(idx * 4 + int'($urandom_range(0, 3)));
      arvalid = 1'b1;
      step();
      chk("arready", 128'(arready), 128'(1));
      step();
      arvalid = 1'b0;
      exp = model_read(idx);
      chk("rvalid", 128'(rvalid), 128'(1));
      chk("rresp", 128'(rresp), 128'(0));
      chk($sformatf("rdata[%0d]", idx), 128'(rdata), 128'(exp));
      val = rdata;
      for (int i = 0; i < rp; i++) begin
         step(); chk("r_hold", 128'({rvalid, rdata}), 128'({1'b1, exp}));
      end
      rready = 1'b1; step(); rready = 1'b0;
      chk("rvalid_clear", 128'(rvalid), 128'(0));
   endtask

   logic [31:0] key_tab [4] = '{32'h00010203, 32'h04050607, 32'h08090a0b, 32'h0c0d0e0f};
   logic [31:0] pt_tab  [4] = '{32'h00112233, 32'h44556677, 32'h8899aabb, 32'hccddeeff};
   logic [31:0] ct_tab  [4] = '{32'h69c4e0d8, 32'h6a7b0430, 32'hd8cdb780, 32'h70b4c55a};
   int          lead_tab [4] = '{3, -3, 0, 1};

   initial begin
      logic [31:0] v;
      logic [1:0]  r;
      int          op, idx;
      logic [31:0] d;
      model_reset();
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;

      for (int i = 0; i < 16; i++) begin
         axi_read(i, 0, v);
         chk("reset_value", 128'(v), 128'(0));
      end

      for (int i = 0; i < 4; i++) axi_write(i, key_tab[i], 4'hf, lead_tab[i], 0, r);
      for (int i = 0; i < 4; i++) begin
         axi_read(i, 0, v);
         chk("key_readback", 128'(v), 128'(key_tab[i]));
      end
      chk("aes_key_lit", aes_key, 128'h000102030405060708090a0b0c0d0e0f);

      for (int i = 0; i < 4; i++) axi_write(4 + i, pt_tab[i], 4'hf, 0, 0, r);
      axi_write(8, 32'h3, 4'h1, 0, 0, r);
      repeat (60) step();
      for (int i = 0; i < 4; i++) begin
         axi_read(10 + i, 0, v);
         chk("ct_lit", 128'(v), 128'(ct_tab[i]));
      end
      axi_read(9, 0, v);  chk("status_done_lit", 128'(v), 128'(32'h2));
      axi_read(14, 0, v); chk("cycles_lit", 128'(v), 128'(41));
      chk("irq_lit", 128'(irq), 128'(1));

      axi_write(8, 32'h3, 4'h1, 0, 0, r);
      axi_write(8, 32'h1, 4'h1, 0, 0, r);
      chk("start_busy_okay", 128'(r), 128'(2'b00));
      axi_write(4, 32'hdeadbeef, 4'hf, 0, 0, r);
      chk("pt_busy_slverr", 128'(r), 128'(2'b10));
      axi_read(9, 0, v); chk("status_busy_ovr_lit", 128'(v), 128'(32'h5));
      repeat (60) step();
      axi_read(4, 0, v); chk("pt0_kept_lit", 128'(v), 128'(32'h00112233));
      axi_read(9, 0, v); chk("status_ovr_lit", 128'(v), 128'(32'h6));

      axi_write(1, 32'h0, 4'hf, 0, 0, r);
      axi_write(1, 32'haabbccdd, 4'b0101, 0, 0, r);
      axi_read(1, 0, v); chk("wstrb_lit", 128'(v), 128'(32'h00bb00dd));
      axi_write(9, 32'h6, 4'h1, 0, 0, r);
      chk("irq_cleared_lit", 128'(irq), 128'(0));
      axi_read(9, 0, v); chk("status_w1c_lit", 128'(v), 128'(32'h0));

      axi_write(5, $urandom, 4'hf, 2, 10, r);
      axi_read(5, 10, v);

      axi_write(8, 32'h1, 4'h1, 0, 0, r);
      repeat (5) step();
      rst_n = 1'b0; model_reset();
      step();
      rst_n = 1'b1;
      repeat (50) step();
      axi_read(9, 0, v);  chk("status_after_reset_lit", 128'(v), 128'(0));
      axi_read(10, 0, v); chk("ct_after_reset_lit", 128'(v), 128'(0));

      for (int n = 0; n < 200; n++) begin
         core_ct = {$urandom, $urandom, $urandom, $urandom};
         op = int'($urandom_range(0, 2));
         idx = int'($urandom_range(0, 15));
         if (op == 0) begin
            axi_read(idx, int'($urandom_range(0, 3)), v);
         end else if (op == 1) begin
            d = $urandom;
            if (idx == 8 && $urandom_range(0, 2) != 0) d[0] = 1'b0;
            axi_write(idx, d, 4'($urandom), int'($urandom_range(0, 6)) - 3,
                      int'($urandom_range(0, 3)), r);
         end else begin
            repeat (int'($urandom_range(0, 5))) step();
         end
      end
      repeat (50) step();
      for (int i = 0; i < 16; i++) axi_read(i, 0, v);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
